// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/gnt/rvalid
// memory handshake and hands them to decode through a valid/ready interface.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus_four,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_FAULT
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        kill, kill_n;
  logic [7:0]  cnt, cnt_n;
  logic [1:0]  cause_n;
  logic        capture;

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_VALID);
  assign fetch_fault = (state == S_FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      pc                 <= RESET_PC;
      kill               <= 1'b0;
      cnt                <= '0;
      fault_cause        <= 2'b00;
      instruction        <= NOP;
      instr_pc           <= RESET_PC;
      instr_pc_plus_four <= RESET_PC + 32'd4;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      kill        <= kill_n;
      cnt         <= cnt_n;
      fault_cause <= cause_n;
      if (capture) begin
        instruction        <= imem_rdata;
        instr_pc           <= pc;
        instr_pc_plus_four <= pc + 32'd4;
      end
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    cnt_n   = cnt;
    cause_n = fault_cause;
    capture = 1'b0;

    case (state)
      S_IDLE:  state_n = S_FETCH;
      S_FETCH: begin
        if (imem_gnt) begin
          state_n = S_WAIT;
          cnt_n   = '0;
          kill_n  = 1'b0;
        end
      end
      S_WAIT: begin
        // Saturate so a redirect held across the limit cannot wrap the counter.
        if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
        if (imem_rvalid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = S_FETCH;
          end else begin
            capture = 1'b1;
            state_n = S_VALID;
          end
        end else if (cnt >= CNT_LAST) begin
          state_n = S_FAULT;
          cause_n = 2'b10;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          pc_n    = pc + 32'd4;
          state_n = S_FETCH;
        end
      end
      S_FAULT: ;
      default: state_n = S_FAULT;
    endcase

    // Redirects override the sequential decisions above in every live state.
    if (redirect_valid && state != S_FAULT) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state_n = S_FAULT;
        cause_n = 2'b01;
        pc_n    = pc;
        capture = 1'b0;
      end else begin
        pc_n = redirect_pc;
        case (state)
          S_FETCH: if (imem_gnt) kill_n = 1'b1;
          S_WAIT: begin
            capture = 1'b0;
            if (imem_rvalid) begin
              kill_n  = 1'b0;
              state_n = S_FETCH;
            end else begin
              kill_n  = 1'b1;
              state_n = S_WAIT;
            end
          end
          S_VALID: state_n = S_FETCH;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run checked against a PC-sequence reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus_four;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int n_run  = 0;
  int n_fail = 0;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .instr_pc_plus_four(instr_pc_plus_four),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic idle_in();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle_in();
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_run++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_run++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC); end
    n_run++; if (instruction !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", instruction, NOP); end
    n_run++; if (instr_pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h want %h", instr_pc, RST_PC); end
    n_run++; if (instr_pc_plus_four !== RST_PC + 32'd4) begin n_fail++; $display("FAIL rst_pc4: got %h want %h", instr_pc_plus_four, RST_PC + 32'd4); end
    n_run++; if (fetch_fault !== 1'b0 || fault_cause !== 2'b00) begin n_fail++; $display("FAIL rst_fault: got %b/%b want 0/00", fetch_fault, fault_cause); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    step();
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL zw_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    step();
    n_run++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_wait: got req=%b valid=%b want 0/0", imem_req, instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    n_run++; if (instr_valid !== 1'b1 || instruction !== 32'h0050_0093) begin n_fail++; $display("FAIL zw_valid: got v=%b instr=%h want 1/00500093", instr_valid, instruction); end
    n_run++; if (instr_pc !== 32'h0 || instr_pc_plus_four !== 32'h4) begin n_fail++; $display("FAIL zw_pc: got %h/%h want 0/4", instr_pc, instr_pc_plus_four); end
    instr_ready = 1'b1;
    step();
    n_run++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_next: got addr=%h req=%b v=%b want 4/1/0", imem_addr, imem_req, instr_valid); end
  endtask

  task automatic test_backpressure();
    imem_gnt = 1'b1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    step();
    for (int i = 0; i < 5; i++) begin
      n_run++; if (instr_valid !== 1'b1 || instruction !== 32'h00A0_0113 || instr_pc !== 32'h4 || imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b instr=%h pc=%h req=%b want 1/00a00113/4/0", i, instr_valid, instruction, instr_pc, imem_req); end
      step();
    end
    n_run++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_still: got %b want 1", instr_valid); end
    instr_ready = 1'b1;
    step();
    n_run++; if (imem_addr !== 32'h8 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_adv: got addr=%h v=%b want 8/0", imem_addr, instr_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step();
    imem_gnt = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    n_run++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rw_kill: got req=%b addr=%h want 0/100", imem_req, imem_addr); end
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_refetch: got req=%b addr=%h v=%b want 1/100/0", imem_req, imem_addr, instr_valid); end
    n_run++; if (instruction !== NOP) begin n_fail++; $display("FAIL rw_stale: got %h want %h", instruction, NOP); end
    imem_gnt = 1'b1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0517;
    step();
    n_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instruction !== 32'h0000_0517) begin n_fail++; $display("FAIL rw_deliver: got v=%b pc=%h instr=%h want 1/100/00000517", instr_valid, instr_pc, instruction); end
  endtask

  task automatic test_redirect_gnt();
    do_reset();
    step();
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    n_run++; if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rg_wait: got req=%b addr=%h want 0/200", imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'hBADC_0DE0;
    step();
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rg_refetch: got req=%b addr=%h v=%b want 1/200/0", imem_req, imem_addr, instr_valid); end
    imem_gnt = 1'b1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0640_0193;
    step();
    n_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instruction !== 32'h0640_0193) begin n_fail++; $display("FAIL rg_deliver: got v=%b pc=%h instr=%h want 1/200/06400193", instr_valid, instr_pc, instruction); end
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    n_run++; if (fetch_fault !== 1'b1 || fault_cause !== 2'b01) begin n_fail++; $display("FAIL mis_fault: got %b/%b want 1/01", fetch_fault, fault_cause); end
    n_run++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mis_quiet: got req=%b v=%b addr=%h want 0/0/0", imem_req, instr_valid, imem_addr); end
    for (int i = 0; i < 4; i++) begin
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; imem_gnt = 1'b1; instr_ready = 1'b1;
      step();
      n_run++; if (fetch_fault !== 1'b1 || fault_cause !== 2'b01 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mis_sticky%0d: got f=%b c=%b req=%b addr=%h want 1/01/0/0", i, fetch_fault, fault_cause, imem_req, imem_addr); end
    end
    do_reset();
    n_run++; if (fetch_fault !== 1'b0 || fault_cause !== 2'b00 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL mis_clear: got f=%b c=%b addr=%h want 0/00/%h", fetch_fault, fault_cause, imem_addr, RST_PC); end
    step();
    n_run++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL mis_restart: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC); end
  endtask

  task automatic test_timeout();
    do_reset();
    step();
    imem_gnt = 1'b1;
    step();
    for (int w = 1; w <= 4; w++) begin
      n_run++; if (fetch_fault !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got f=%b req=%b want 0/0", w, fetch_fault, imem_req); end
      step();
    end
    n_run++; if (fetch_fault !== 1'b1 || fault_cause !== 2'b10 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL to_fault: got f=%b c=%b v=%b req=%b want 1/10/0/0", fetch_fault, fault_cause, instr_valid, imem_req); end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F;
    step();
    n_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc_plus_four !== 32'h0) begin n_fail++; $display("FAIL wr_pc4: got v=%b pc=%h pc4=%h want 1/fffffffc/0", instr_valid, instr_pc, instr_pc_plus_four); end
    instr_ready = 1'b1;
    step();
    n_run++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wr_next: got addr=%h req=%b want 0/1", imem_addr, imem_req); end
  endtask

  // Random memory latency, back-pressure and redirects; the model only tracks
  // which PC the next delivered instruction must come from.
  task automatic test_random();
    logic        pend;
    logic [31:0] paddr;
    int          pdly;
    logic [31:0] exp_pc;
    logic        prev_hold, prev_redir_v;
    logic [31:0] prev_instr, prev_pc, prev_pc4;
    do_reset();
    exp_pc = RST_PC; pend = 1'b0; paddr = 32'h0; pdly = 0;
    prev_hold = 1'b0; prev_redir_v = 1'b0;
    prev_instr = 32'h0; prev_pc = 32'h0; prev_pc4 = 32'h0;
    for (int c = 0; c < 800; c++) begin
      if (instr_valid === 1'b1) begin
        n_run++; if (instr_pc !== exp_pc || instruction !== mem_word(exp_pc) || instr_pc_plus_four !== exp_pc + 32'd4) begin n_fail++; $display("FAIL rnd_deliver@%0d: got pc=%h instr=%h pc4=%h want %h/%h/%h", c, instr_pc, instruction, instr_pc_plus_four, exp_pc, mem_word(exp_pc), exp_pc + 32'd4); end
      end
      if (prev_hold) begin
        n_run++; if (instr_valid !== 1'b1 || instruction !== prev_instr || instr_pc !== prev_pc || instr_pc_plus_four !== prev_pc4) begin n_fail++; $display("FAIL rnd_hold@%0d: got v=%b instr=%h pc=%h want 1/%h/%h", c, instr_valid, instruction, instr_pc, prev_instr, prev_pc); end
      end
      if (prev_redir_v) begin
        n_run++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drop@%0d: got v=%b want 0", c, instr_valid); end
      end
      n_run++; if (fetch_fault !== 1'b0 || (imem_req === 1'b1 && instr_valid === 1'b1)) begin n_fail++; $display("FAIL rnd_ctrl@%0d: got f=%b req=%b v=%b want 0 and not req&v", c, fetch_fault, imem_req, instr_valid); end

      imem_rvalid    = pend && (pdly == 0);
      imem_rdata     = imem_rvalid ? mem_word(paddr) : $urandom;
      imem_gnt       = imem_req && !pend && ($urandom_range(0, 99) < 60);
      instr_ready    = ($urandom_range(0, 99) < 50);
      redirect_valid = ($urandom_range(0, 99) < 10);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;

      prev_hold    = instr_valid && !instr_ready && !redirect_valid;
      prev_redir_v = instr_valid && redirect_valid;
      prev_instr   = instruction; prev_pc = instr_pc; prev_pc4 = instr_pc_plus_four;
      if (redirect_valid) exp_pc = redirect_pc;
      else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
      if (imem_rvalid) pend = 1'b0;
      else if (pend) pdly--;
      if (imem_gnt) begin
        pend = 1'b1; paddr = imem_addr; pdly = $urandom_range(0, 2);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_misaligned();
    test_timeout();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
